// File: rtl/mem_bus_pkg.sv
// Shared definitions for the BRAM memory-bus initiators: FSM encoding, bus word size
// and the default prefetch depth.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } reader_state_e;

    localparam int unsigned MEM_WORD_BYTES     = 4;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. Read data reads as zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CountW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == CountW'(DEPTH));
    assign o_empty = (r_count == '0);

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CountW'(1);
                2'b01:   r_count <= r_count - CountW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/mem_stream_reader.sv
// Reads word_count consecutive words from BRAM and streams them out via a prefetch FIFO.
// A slot is reserved per strobe, so the FIFO can never overflow on capture.
module mem_stream_reader
    import mem_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_addr,
    output logic             mem_rstrb,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    reader_state_e r_state;
    reader_state_e w_state_d;

    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_inflight;
    logic             r_rstrb;
    logic [31:0]      r_mem_addr;
    logic             r_busy;
    logic             r_done;

    logic [CountW-1:0] w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CountW:0]   w_reserved;
    logic              w_accept;
    logic              w_issue;
    logic              w_drained;
    logic              w_finish;
    logic              w_pop;

    // Strobe on the bus and word returning this cycle both already own a FIFO slot.
    assign w_reserved = {1'b0, w_fifo_count} + (CountW + 1)'(r_rstrb)
                      + (CountW + 1)'(r_inflight);
    assign w_drained  = !r_rstrb && !r_inflight && w_fifo_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                // A zero-length request passes through DRAIN only to produce done.
                if (start) w_state_d = (word_count == '0) ? StDrain : StFetch;
            end
            StFetch: begin
                if (w_issue && r_remaining == CNT_W'(1)) w_state_d = StDrain;
            end
            StDrain: begin
                if (w_drained) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_accept = (r_state == StIdle) && start;
        w_issue  = (r_state == StFetch) && (w_reserved < (CountW + 1)'(FIFO_DEPTH));
        w_finish = (r_state == StDrain) && w_drained;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_rstrb     <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= r_rstrb;
            r_rstrb    <= w_issue;
            r_done     <= w_finish;
            if (w_accept) begin
                r_addr      <= word_align(base_addr);
                r_remaining <= word_count;
            end else if (w_issue) begin
                r_addr      <= r_addr + 32'(MEM_WORD_BYTES);
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_issue) r_mem_addr <= r_addr;
            if (w_accept && word_count != '0) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_pop = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_push  (r_inflight),
        .i_wdata (mem_rdata),
        .i_pop   (w_pop),
        .o_rdata (out_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rstrb = r_rstrb;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = '0;
    assign mem_wmask = '0;

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a small BRAM model holding MEM[i]=0xA0000000+i.
module tb_mem_stream_reader;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    mem_stream_reader #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rstrb  (mem_rstrb),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] bram [64];
    initial for (int i = 0; i < 64; i++) bram[i] = 32'hA000_0000 + 32'(i);

    always @(posedge clk) if (mem_rstrb) mem_rdata <= bram[mem_addr[7:2]];

    // Monitor: record stream words, strobe addresses and pulse counts.
    logic [31:0] got_q[$];
    logic [31:0] addr_q[$];
    int rstrb_cnt = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (mem_rstrb) begin
            addr_q.push_back(mem_addr);
            rstrb_cnt++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] first);
        check({tag, "_len"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            check({tag, "_word"}, got_q[i], first + 32'(i));
    endtask

    int r0;
    int d0;
    int b0;
    int lat;

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("wdata_tie", mem_wdata, 32'd0);
        check("wmask_tie", {28'd0, mem_wmask}, 32'd0);
        resetn = 1'b1;

        // Basic transfer and start-to-valid latency.
        out_ready = 1'b1;
        got_q.delete(); addr_q.delete();
        r0 = rstrb_cnt; d0 = done_cnt;
        kick(32'h10, 16'd4);
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check("basic_busy", {31'd0, busy}, 32'd1);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("basic_latency", 32'(lat), 32'd3);
        wait_done(40, "basic");
        check_stream("basic", 4, 32'hA000_0004);
        check("basic_strobes", 32'(rstrb_cnt - r0), 32'd4);
        check("basic_addr0", addr_q.size() > 0 ? addr_q[0] : 32'hDEAD, 32'h10);
        check("basic_dones", 32'(done_cnt - d0), 32'd1);

        // Zero count: done the cycle after start, no bus activity, busy never high.
        r0 = rstrb_cnt; b0 = busy_cnt; d0 = done_cnt;
        kick(32'h20, 16'd0);
        @(negedge clk);
        check("zero_done_c0", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("zero_done_c1", {31'd0, done}, 32'd1);
        repeat (5) @(negedge clk);
        check("zero_strobes", 32'(rstrb_cnt - r0), 32'd0);
        check("zero_busy", 32'(busy_cnt - b0), 32'd0);
        check("zero_dones", 32'(done_cnt - d0), 32'd1);

        // Backpressure: FIFO_DEPTH strobes then stall.
        out_ready = 1'b0;
        got_q.delete(); addr_q.delete();
        r0 = rstrb_cnt;
        kick(32'h0, 16'd10);
        repeat (20) @(negedge clk);
        check("bp_strobes", 32'(rstrb_cnt - r0), 32'd4);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head", out_data, 32'hA000_0000);
        check("bp_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(80, "bp");
        check_stream("bp", 10, 32'hA000_0000);
        check("bp_total_strobes", 32'(rstrb_cnt - r0), 32'd10);

        // Address wrap.
        got_q.delete(); addr_q.delete();
        kick(32'hFFFF_FFF8, 16'd3);
        wait_done(40, "wrap");
        check("wrap_nstrb", 32'(addr_q.size()), 32'd3);
        if (addr_q.size() == 3) begin
            check("wrap_a0", addr_q[0], 32'hFFFF_FFF8);
            check("wrap_a1", addr_q[1], 32'hFFFF_FFFC);
            check("wrap_a2", addr_q[2], 32'h0000_0000);
        end
        check("wrap_len", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("wrap_d0", got_q[0], 32'hA000_003E);
            check("wrap_d1", got_q[1], 32'hA000_003F);
            check("wrap_d2", got_q[2], 32'hA000_0000);
        end

        // Unaligned base, plus a start while busy that must be ignored.
        got_q.delete(); addr_q.delete();
        r0 = rstrb_cnt; d0 = done_cnt;
        kick(32'h13, 16'd2);
        #1;
        start = 1'b1; base_addr = 32'h40; word_count = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, "unal");
        repeat (10) @(negedge clk);
        check("unal_addr0", addr_q.size() > 0 ? addr_q[0] : 32'hDEAD, 32'h10);
        check("unal_strobes", 32'(rstrb_cnt - r0), 32'd2);
        check("unal_dones", 32'(done_cnt - d0), 32'd1);
        check_stream("unal", 2, 32'hA000_0004);

        // Reset mid-transfer.
        out_ready = 1'b0;
        r0 = rstrb_cnt;
        kick(32'h0, 16'd8);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rstrb_cnt - r0 >= 2) break;
        end
        check("rst_mid_progress", 32'(rstrb_cnt - r0 >= 2), 32'd1);
        @(negedge clk);
        #2;
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check("rmid_addr", mem_addr, 32'd0);
        check("rmid_valid", {31'd0, out_valid}, 32'd0);
        check("rmid_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("rmid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rmid_idle_valid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b1;
        got_q.delete(); addr_q.delete();
        r0 = rstrb_cnt; d0 = done_cnt;
        kick(32'h20, 16'd8);
        wait_done(60, "after_rst");
        check_stream("after_rst", 8, 32'hA000_0008);
        check("after_rst_strobes", 32'(rstrb_cnt - r0), 32'd8);
        check("after_rst_dones", 32'(done_cnt - d0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Bus initiator for the word-addressed BRAM memory bus (mem_addr / mem_rstrb / mem_rdata / mem_wdata / mem_wmask). Given a base byte address and a word count, it issues single-word reads to the BRAM, captures the returned data and presents it as a valid/ready stream through a small prefetch FIFO. It sits between on-chip BRAM and any streaming consumer, such as the display/shift-out path, and gives that consumer a memory-to-stream path without processor involvement.

## Interface
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of word_count.
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  32  byte address of first word; bits [1:0] ignored.
- word_count  in  CNT_W  number of 32-bit words to read.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transfer end.
- mem_addr  out  32  read address; bits [1:0] always 0.
- mem_rstrb  out  1  read strobe, one cycle per word.
- mem_rdata  in  32  BRAM read data, valid the cycle after mem_rstrb.
- mem_wdata  out  32  tied to 0.
- mem_wmask  out  4  tied to 0; this block never writes.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when valid and ready are both high.

## Operation
- Reset: state IDLE, busy=0, done=0, mem_rstrb=0, mem_addr=0, out_valid=0, out_data=0, FIFO empty, inflight=0, remaining=0.
- Registers: addr (32), remaining (CNT_W), inflight (1 bit: a strobe was issued last cycle).
- IDLE, start=1, word_count!=0: load addr={base_addr[31:2],2'b00} and remaining=word_count, then go to FETCH with busy=1.
- IDLE, start=1, word_count==0: done pulses next cycle, busy stays 0, no bus activity.
- FETCH: assert mem_rstrb with mem_addr=addr when fifo_count + inflight < FIFO_DEPTH. On each strobe, addr+=4 and remaining-=1. When the strobe carrying remaining==1 issues, go to DRAIN.
- Capture: when inflight=1, push mem_rdata into the FIFO. A push always has room because it was reserved when the strobe issued.
- DRAIN: no strobes. When inflight=0 and the FIFO is empty, pulse done, clear busy and return to IDLE.
- start while busy: ignored; it is not queued.
- Address wrap: addr increments modulo 2^32; 0xFFFFFFFC+4 gives 0x00000000 with no error.
- Simultaneous push and pop on the FIFO: both take effect and the count is unchanged. A pop on a full FIFO with a push in the same cycle is legal.
- out_data/out_valid: driven from the FIFO head. out_data holds while out_valid=1 and out_ready=0.
- Reset mid-transfer: aborts immediately. FIFO is flushed, in-flight data is discarded, done is not pulsed.

## Timing
- Cycle 0: start sampled. Cycle 1: first mem_rstrb. Cycle 2: mem_rdata captured into the FIFO. Cycle 3: out_valid=1. Start to first out_valid is 3 cycles.
- mem_rstrb and mem_addr are registered outputs.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: strobes stop within 1 cycle once reserved slots reach FIFO_DEPTH, and resume the cycle after a pop frees a slot.
- done pulses the cycle after the last word is popped. busy falls in the same cycle done is high.

## Structure
- Shared package mem_bus_pkg holds:
  - the state encoding: IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2;
  - MEM_WORD_BYTES=4;
  - the default FIFO_DEPTH.
- Sub-module sync_fifo(WIDTH=32, DEPTH=FIFO_DEPTH): single-clock FIFO with async active-low reset, plus count, full and empty outputs. It is reusable by other stream blocks.
- Top level contains the FSM, address/remaining counters and the inflight flag.

## Test plan
- Basic transfer: BRAM model preloaded with MEM[i]=0xA0000000+i, base_addr=0x10, word_count=4, out_ready=1 → stream 0xA0000004..0xA0000007 in order, mem_rstrb high 4 cycles, done one pulse, first out_valid 3 cycles after start.
- Zero count: start with word_count=0 → done pulse next cycle, no mem_rstrb, busy never high.
- Backpressure: word_count=10, out_ready=0 for 20 cycles → exactly FIFO_DEPTH strobes issued. After out_ready=1, all 10 words arrive in order with no duplicates or gaps.
- Wrap: base_addr=0xFFFFFFF8, word_count=3 → mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Unaligned base and ignored start: base_addr=0x13 → first mem_addr=0x10. A second start during busy causes no extra transfer.
- Reset mid-transfer: assert resetn=0 after 2 of 8 words → all outputs 0 immediately, no done pulse. A new start then runs a clean full transfer.
